// File: rtl/eightbit_serial_subtractor_2bit.sv
// Serial subtractor: one 2-bit slice per clock, with valid/ready handshakes on the operand and result sides.
// Build option: define APPROX_LSB_SLICE_EN to compute slice 0 as a borrow-free XOR approximation.
module eightbit_serial_subtractor_2bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             bout
);
   localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH / 2 - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] out_r;
   logic             bout_r;
   logic             borrow_r;
   logic [IDX_W-1:0] idx_r;
   logic [1:0]       d_s;
   logic             b_s;
   logic             in_ready_s;
   logic             out_valid_s;

   // {borrow, diff} of one slice: a - b - bin in 3-bit two's complement.
   function automatic logic [2:0] slice_sub(input logic [1:0] a, input logic [1:0] b, input logic bin);
      slice_sub = {1'b0, a} - {1'b0, b} - {2'b00, bin};
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_nxt_s = RUN;
            else          state_nxt_s = IDLE;
         end
         RUN: begin
            if (idx_r == LAST_IDX) state_nxt_s = DONE;
            else                   state_nxt_s = RUN;
         end
         DONE: begin
            if (out_ready) state_nxt_s = IDLE;
            else           state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         IDLE:    in_ready_s  = 1'b1;
         RUN:     in_ready_s  = 1'b0;
         DONE:    out_valid_s = 1'b1;
         default: in_ready_s  = 1'b0;
      endcase
   end

   // Current slice: operands are shifted right so the active slice always sits in bits [1:0]
   always_comb begin
      {b_s, d_s} = slice_sub(a_r[1:0], b_r[1:0], borrow_r);
`ifdef APPROX_LSB_SLICE_EN
      if (idx_r == {IDX_W{1'b0}}) begin
         d_s = a_r[1:0] ^ b_r[1:0];
         b_s = 1'b0;
      end else begin
         {b_s, d_s} = slice_sub(a_r[1:0], b_r[1:0], borrow_r);
      end
`endif
   end

   // Datapath: operand capture, slice shifting and result assembly from the MSB end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         out_r    <= {WIDTH{1'b0}};
         bout_r   <= 1'b0;
         borrow_r <= 1'b0;
         idx_r    <= {IDX_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= in0;
                  b_r      <= in1;
                  out_r    <= {WIDTH{1'b0}};
                  bout_r   <= 1'b0;
                  borrow_r <= 1'b0;
                  idx_r    <= {IDX_W{1'b0}};
               end
            end
            RUN: begin
               a_r      <= a_r >> 2;
               b_r      <= b_r >> 2;
               out_r    <= WIDTH'({d_s, out_r} >> 2);
               borrow_r <= b_s;
               bout_r   <= b_s;
               idx_r    <= idx_r + IDX_W'(1);
            end
            DONE: begin
               out_r <= out_r;
            end
            default: begin
               out_r <= out_r;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign out       = out_r;
   assign bout      = bout_r;

endmodule

// File: tb/tb_eightbit_serial_subtractor_2bit.sv
// Directed bench for eightbit_serial_subtractor_2bit (WIDTH=8): latency, handshake, reset and arithmetic checks.
module tb_eightbit_serial_subtractor_2bit;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in0;
   logic [7:0] in1;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out;
   logic       bout;

   int nvec  = 0;
   int nfail = 0;

`ifdef APPROX_LSB_SLICE_EN
   localparam logic [8:0] R_5A_3C = {1'b0, 8'h1E};
   localparam logic [8:0] R_00_01 = {1'b0, 8'h01};
   localparam logic [8:0] R_FF_FF = {1'b0, 8'h00};
   localparam logic [8:0] R_10_01 = {1'b0, 8'h11};
   localparam logic [8:0] R_80_7F = {1'b0, 8'h07};
   localparam logic [8:0] R_33_11 = {1'b0, 8'h22};
   localparam logic [8:0] R_05_03 = {1'b0, 8'h06};
   localparam logic [8:0] R_03_05 = {1'b1, 8'hFE};
`else
   localparam logic [8:0] R_5A_3C = {1'b0, 8'h1E};
   localparam logic [8:0] R_00_01 = {1'b1, 8'hFF};
   localparam logic [8:0] R_FF_FF = {1'b0, 8'h00};
   localparam logic [8:0] R_10_01 = {1'b0, 8'h0F};
   localparam logic [8:0] R_80_7F = {1'b0, 8'h01};
   localparam logic [8:0] R_33_11 = {1'b0, 8'h22};
   localparam logic [8:0] R_05_03 = {1'b0, 8'h02};
   localparam logic [8:0] R_03_05 = {1'b1, 8'hFE};
`endif

   eightbit_serial_subtractor_2bit #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .in1       (in1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .bout      (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation: accept, 3 RUN edges with input noise, DONE, optional hold, release.
   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] res, input int hold);
      chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
      in0 = a; in1 = b; in_valid = 1'b1; out_ready = 1'b0;
      step();
      chk({tag, "_acc_rdy"}, 32'(in_ready), 32'd0);
      in0 = ~a; in1 = ~b;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk({tag, "_run_vld"}, 32'(out_valid), 32'd0);
      end
      step();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_out"}, 32'(out), 32'(res[7:0]));
      chk({tag, "_bout"}, 32'(bout), 32'(res[8]));
      for (int h = 0; h < hold; h++) begin
         step();
         chk({tag, "_hold"}, {22'd0, in_ready, out_valid, out}, {22'd0, 1'b0, 1'b1, res[7:0]});
         chk({tag, "_hold_bout"}, 32'(bout), 32'(res[8]));
      end
      out_ready = 1'b1; in0 = a; in1 = b; in_valid = 1'b1;
      step();
      chk({tag, "_rel_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_rel_noacc"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in0 = 8'h00; in1 = 8'h00;
      #3;
      chk("rst_state", {22'd0, in_ready, out_valid, bout, out}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      #20 rst_n = 1'b1;

      do_op("sub_5a_3c", 8'h5A, 8'h3C, R_5A_3C, 0);
      do_op("sub_00_01", 8'h00, 8'h01, R_00_01, 0);
      do_op("sub_ff_ff", 8'hFF, 8'hFF, R_FF_FF, 0);
      do_op("sub_10_01", 8'h10, 8'h01, R_10_01, 0);
      do_op("sub_80_7f", 8'h80, 8'h7F, R_80_7F, 10);

      // Reset after the second RUN edge of an operation
      in0 = 8'hC3; in1 = 8'h42; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst", {22'd0, in_ready, out_valid, bout, out}, {22'd0, 1'b1, 1'b0, 1'b0, 8'h00});
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rst_hold_vld", 32'(out_valid), 32'd0);
      end
      #2 rst_n = 1'b1;
      do_op("sub_33_11", 8'h33, 8'h11, R_33_11, 0);

      // Back-to-back with in_valid and out_ready held high
      in0 = 8'h05; in1 = 8'h03; in_valid = 1'b1; out_ready = 1'b1;
      chk("b2b_rdy0", 32'(in_ready), 32'd1);
      step();
      chk("b2b_acc0", 32'(in_ready), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("b2b_run0", 32'(out_valid), 32'd0);
      end
      step();
      chk("b2b_res0", {23'd0, out_valid, bout, out}, {23'd0, 1'b1, R_05_03});
      in0 = 8'h03; in1 = 8'h05;
      step();
      chk("b2b_exit", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      step();
      chk("b2b_acc1", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("b2b_run1", 32'(out_valid), 32'd0);
      end
      step();
      chk("b2b_res1", {23'd0, out_valid, bout, out}, {23'd0, 1'b1, R_03_05});
      step();
      chk("b2b_done", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
